// File: rtl/switch_debounce.sv
// switch_debounce
//   Conditions raw slide-switch inputs before the downstream ones-count stage.
//   Each switch bit passes through a SYNC_STAGES-deep synchronizer, then a
//   per-bit debounce counter. A new level must hold DB_CYCLES consecutive
//   clocks before it is accepted onto SW.
//
// Parameters
//   NUM_SW       number of switch bits conditioned
//   SYNC_STAGES  synchronizer depth (>= 2)
//   DB_CYCLES    consecutive clocks a new level must hold (>= 1)
//
// Ports
//   clk         in   system clock, all state on rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   SW_raw      in   raw switch pins, asynchronous to clk
//   SW          out  debounced switch levels
//   SW_changed  out  registered 1-clk pulse when any SW bit updated
//   busy        out  registered, high while any bit's counter is nonzero
//   sw_rise     out  (SW_EDGE_PULSE_EN only) per-bit 0->1 pulse, aligned with SW_changed
//   sw_fall     out  (SW_EDGE_PULSE_EN only) per-bit 1->0 pulse, aligned with SW_changed
//
// Configuration
//   SW_EDGE_PULSE_EN  when defined, adds the sw_rise / sw_fall outputs.
//
// Debug visibility
//   w_state[i] holds the per-bit FSM state (STABLE / SETTLING), decoded from
//   the bit's counter; bind checkers to it.
//
// Handshake
//   No valid/ready handshake: SW is a level output, and SW_changed (plus
//   sw_rise/sw_fall) marks the single cycle in which a new SW value first
//   appears.

module switch_debounce #(
  parameter int NUM_SW      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic              clk,
  input  logic              CPU_RESETN,
  input  logic [NUM_SW-1:0] SW_raw,
  output logic [NUM_SW-1:0] SW,
  output logic              SW_changed,
`ifdef SW_EDGE_PULSE_EN
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // Counter value seen on the edge that commits (zero when DB_CYCLES == 1,
  // so a STABLE bit commits on its first mismatch).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  // Synchronizer chain; stage 0 is the only logic that samples SW_raw.
  logic [NUM_SW-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SW-1:0] w_sync_q;

  logic [CNT_W-1:0]  r_cnt      [NUM_SW];
  logic [CNT_W-1:0]  w_cnt_next [NUM_SW];
  state_e            w_state    [NUM_SW];
  logic [NUM_SW-1:0] w_commit;
  logic              w_any_cnt;

  logic [NUM_SW-1:0] r_sw;
  logic              r_changed;
  logic              r_busy;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= SW_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Per-bit debounce FSM. State is implied by the counter: zero is STABLE,
  // nonzero is SETTLING. A commit flips SW[i] to the synchronized level,
  // which always differs from SW[i] on the committing edge.
  always_comb begin
    w_any_cnt = 1'b0;
    w_commit  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_state[i]    = (r_cnt[i] == '0) ? ST_STABLE : ST_SETTLING;
      w_cnt_next[i] = r_cnt[i];
      case (w_state[i])
        ST_STABLE: begin
          if (w_sync_q[i] != r_sw[i]) begin
            if (CNT_LAST == '0) begin
              w_commit[i] = 1'b1;
            end else begin
              w_cnt_next[i] = CNT_W'(1);
            end
          end
        end
        ST_SETTLING: begin
          if (w_sync_q[i] == r_sw[i]) begin
            // Glitch shorter than DB_CYCLES: drop the partial count.
            w_cnt_next[i] = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_commit[i]   = 1'b1;
            w_cnt_next[i] = '0;
          end else begin
            w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_next[i] = '0;
        end
      endcase
      w_any_cnt = w_any_cnt | (w_cnt_next[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < NUM_SW; i++) begin
        r_cnt[i] <= '0;
      end
      r_sw      <= '0;
      r_changed <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_sw      <= r_sw ^ w_commit;
      r_changed <= |w_commit;
      // busy tracks the counters as they stand after this edge.
      r_busy    <= w_any_cnt;
    end
  end

  assign SW         = r_sw;
  assign SW_changed = r_changed;
  assign busy       = r_busy;

`ifdef SW_EDGE_PULSE_EN
  logic [NUM_SW-1:0] r_rise;
  logic [NUM_SW-1:0] r_fall;

  // On a committing edge the new level is the synchronized level.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_commit & w_sync_q;
      r_fall <= w_commit & ~w_sync_q;
    end
  end

  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce with DB_CYCLES=4, SYNC_STAGES=2, NUM_SW=3.
// The downstream ones-count stage (SW -> LED) is modelled here.

module tb_switch_debounce;

  localparam int NUM_SW = 3;
  localparam int SYNC   = 2;
  localparam int DB     = 4;
  localparam int LAT    = SYNC + DB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              CPU_RESETN;
  logic [NUM_SW-1:0] SW_raw;
  logic [NUM_SW-1:0] SW;
  logic              SW_changed;
  logic              busy;
`ifdef SW_EDGE_PULSE_EN
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  switch_debounce #(
    .NUM_SW      (NUM_SW),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clk        (clk),
    .CPU_RESETN (CPU_RESETN),
    .SW_raw     (SW_raw),
    .SW         (SW),
    .SW_changed (SW_changed),
`ifdef SW_EDGE_PULSE_EN
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
`endif
    .busy       (busy)
  );

  // Downstream ones-count stage.
  logic [1:0] led;
  assign led = 2'(SW[0]) + 2'(SW[1]) + 2'(SW[2]);

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_SW-1:0] exp_q[$];
  int                exp_cyc_q[$];
  logic [NUM_SW-1:0] exp_sw_model = '0;
  logic [NUM_SW-1:0] mon_prev = '0;

  function automatic logic [31:0] popcount(input logic [NUM_SW-1:0] v);
    logic [31:0] c;
    c = 0;
    for (int i = 0; i < NUM_SW; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [NUM_SW-1:0] v);
    exp_q.push_back(v);
    exp_cyc_q.push_back(cyc + LAT);
    exp_sw_model = v;
  endtask

  // Drive a level that is held long enough to commit.
  task automatic drive(input logic [NUM_SW-1:0] v);
    SW_raw = v;
    if (v != exp_sw_model) push_exp(v);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (SW_changed) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sw_changed", 32'(SW_changed), 32'd0);
      end else begin
        logic [NUM_SW-1:0] e;
        int                c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("commit_sw", 32'(SW), 32'(e));
        check("commit_cycle", 32'(cyc), 32'(c));
        check("commit_led", 32'(led), popcount(e));
`ifdef SW_EDGE_PULSE_EN
        check("commit_rise", 32'(sw_rise), 32'(e & ~mon_prev));
        check("commit_fall", 32'(sw_fall), 32'(~e & mon_prev));
`endif
        mon_prev = e;
      end
    end
`ifdef SW_EDGE_PULSE_EN
    else begin
      check("idle_rise_fall", 32'({sw_rise, sw_fall}), 32'd0);
    end
`endif
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    CPU_RESETN = 1'b0;
    SW_raw     = 3'b111;

    // 1: reset holds everything low even with all switches high
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_sw", 32'(SW), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_changed", 32'(SW_changed), 32'd0);
    end
    CPU_RESETN = 1'b1;
    SW_raw     = 3'b000;
    wait_clks(8);
    check("idle_sw", 32'(SW), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // 2: clean step on bit 0; busy high for the 3 clocks before commit
    drive(3'b001);
    wait_clks(2);
    check("step_busy_early", 32'(busy), 32'd0);
    wait_clks(1);
    check("step_busy_first", 32'(busy), 32'd1);
    wait_clks(2);
    check("step_busy_last", 32'(busy), 32'd1);
    check("step_sw_before", 32'(SW), 32'd0);
    wait_clks(1);
    check("step_busy_after", 32'(busy), 32'd0);
    check("step_sw_after", 32'(SW), 32'd1);
    wait_clks(4);

    // 3: 3-clock glitch on bit 1 is rejected
    SW_raw = 3'b011;
    wait_clks(3);
    SW_raw = 3'b001;
    wait_clks(1);
    check("glitch_busy_mid", 32'(busy), 32'd1);
    wait_clks(6);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_sw", 32'(SW), 32'd1);

    // 4: simultaneous commit of two bits
    drive(3'b000);
    wait_clks(10);
    drive(3'b101);
    wait_clks(10);
    check("simul_sw", 32'(SW), 32'd5);
    check("simul_led", 32'(led), 32'd2);

    // 5: reset mid-settle discards the partial count
    drive(3'b000);
    wait_clks(10);
    SW_raw = 3'b010;
    wait_clks(4);
    CPU_RESETN = 1'b0;
    wait_clks(1);
    check("midrst_sw", 32'(SW), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    wait_clks(1);
    CPU_RESETN = 1'b1;
    push_exp(3'b010);
    wait_clks(5);
    check("midrst_sw_pre", 32'(SW), 32'd0);
    wait_clks(5);

    // 6: sweep all values through the ones-count stage
    for (int v = 0; v < 8; v++) begin
      drive(3'(v));
      wait_clks(10);
      check("sweep_led", 32'(led), popcount(3'(v)));
    end

    // drain
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
